video_timing_ctrl: RTL and testbench
====================================

Name: video_timing_ctrl

Overview:
- Master raster sequencer for the video output path.
- Generates horizontal/vertical sync, pixel column/row counts and the active-video flag that drive the pattern/pixel datapath.
- Schedules one line-buffer fetch request per active line to the memory arbiter through a req/ack handshake, and detects late fetches (underrun).
- Sits between the top level and the pixel datapath; all outputs are registered and mutually aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of o_hsync/o_vsync (0 = active-low)
- COUNT_W, 10, width of the column/row counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clock  in  1  pixel clock; all logic on its rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  run the raster; low = hold at the last pixel of the frame
- o_col  out  COUNT_W  current column, 0..H_TOTAL-1
- o_row  out  COUNT_W  current row, 0..V_TOTAL-1
- o_hsync  out  1  horizontal sync at SYNC_POL level when asserted
- o_vsync  out  1  vertical sync at SYNC_POL level when asserted
- o_active  out  1  (o_col < H_ACTIVE) && (o_row < V_ACTIVE)
- o_frame_start  out  1  one-cycle pulse when outputs show (0,0)
- o_fetch_req  out  1  line-fetch request to the memory arbiter
- o_fetch_line  out  COUNT_W  row number being requested; stable while o_fetch_req is high
- i_fetch_ack  in  1  arbiter accepts; the transfer completes in a cycle with o_fetch_req && i_fetch_ack
- o_underrun  out  1  sticky: a requested line was not acked before it went active
- i_underrun_clr  in  1  clears o_underrun

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL similarly (525).
- Reset (i_reset low, asynchronous):
  - o_col = H_TOTAL-1, o_row = V_TOTAL-1.
  - o_hsync = o_vsync = !SYNC_POL.
  - o_active, o_frame_start, o_fetch_req, o_underrun = 0; o_fetch_line = 0; fetch FSM in IDLE.
- Counting:
  - While i_enable is high, o_col increments each cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, o_row increments and wraps V_TOTAL-1 -> 0.
  - While i_enable is low, o_col and o_row hold at H_TOTAL-1 and V_TOTAL-1, and all syncs/flags are inactive.
  - The first enabled cycle therefore presents (0,0) with o_frame_start = 1.
- Alignment and latency:
  - o_hsync, o_vsync, o_active and o_frame_start are computed from the next counter values and registered with them, so every output in a cycle describes the same (o_col, o_row).
  - No extra pipeline latency.
- hsync is asserted for H_ACTIVE+H_FRONT <= o_col < H_ACTIVE+H_FRONT+H_SYNC (656..751).
- vsync is asserted for V_ACTIVE+V_FRONT <= o_row < V_ACTIVE+V_FRONT+V_SYNC (490..491) and spans whole lines, changing at o_col = 0.
- Fetch FSM, states IDLE and REQ:
  - IDLE -> REQ in the cycle after outputs show o_col = H_ACTIVE, provided the next row N is active.
    - N = o_row+1, or 0 when o_row = V_TOTAL-1.
    - "Active" means N < V_ACTIVE.
  - On that transition o_fetch_req = 1 and o_fetch_line = N.
  - REQ -> IDLE when i_fetch_ack is high; o_fetch_req drops in the next cycle.
  - REQ -> IDLE at deadline: outputs reach (0, o_fetch_line) with no ack yet. o_underrun sets and the request is withdrawn.
  - Ack in the same cycle as the deadline counts as success; no underrun is flagged.
  - No fetch is issued for row 0 of the first frame after enable or reset, and no underrun is flagged for it.
- Underrun:
  - o_underrun is set only by the deadline transition.
  - If a set and i_underrun_clr occur in the same cycle, set wins.
- i_enable falling while in REQ: the request is withdrawn next cycle, the FSM returns to IDLE, and o_underrun is unchanged.
- Reset mid-request: o_fetch_req drops immediately (asynchronous); no ack is expected afterwards.

Test Plan:
- Reset: assert i_reset=0 with random inputs -> o_col=799, o_row=524, o_hsync=o_vsync=1, o_fetch_req=0, o_underrun=0.
- Free run: enable and run one frame with ack tied high -> exactly one o_frame_start per 420000 cycles; hsync low for 96 cycles starting at col 656; vsync low on rows 490-491; o_active high for 640x480 pixels.
- Fetch handshake: ack delayed 5 cycles -> o_fetch_req rises at (641,k) for each k in 0..478 with o_fetch_line=k+1, holds 5 cycles, then drops; row 524 requests line 0; o_underrun stays 0.
- Underrun: no ack for line 10 -> o_fetch_req drops as outputs reach (0,10), o_underrun=1; pulse i_underrun_clr -> 0; clear and set in the same cycle -> stays 1.
- Deadline ack: ack exactly in the cycle outputs reach (0,N) -> request completes, no underrun.
- Disable/reset mid-REQ: drop i_enable during REQ -> req=0 next cycle, counters at (799,524); re-enable -> o_frame_start at (0,0). Repeat with i_reset pulse -> immediate reset values.

Source files
------------

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster sequencer producing aligned sync/position/active outputs and scheduling one line fetch per active line
module video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_POL = 0,
  parameter int COUNT_W  = 10
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  output logic [COUNT_W-1:0] o_col,
  output logic [COUNT_W-1:0] o_row,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_active,
  output logic               o_frame_start,
  output logic               o_fetch_req,
  output logic [COUNT_W-1:0] o_fetch_line,
  input  logic               i_fetch_ack,
  output logic               o_underrun,
  input  logic               i_underrun_clr
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_ACT    = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT    = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] HS_START = COUNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_END   = COUNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COUNT_W-1:0] VS_START = COUNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_END   = COUNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic ASSERTED = (SYNC_POL != 0);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] col_q, col_d, row_q, row_d, line_q, line_d, next_row;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic               fs_q, fs_d, und_q, und_d, deadline, und_set;

  // next raster position; disabled parks on the last pixel so the first enabled cycle shows (0,0)
  always_comb begin
    next_row = row_q == V_LAST ? '0 : row_q + 1'b1;
    col_d    = !i_enable ? H_LAST : (col_q == H_LAST ? '0 : col_q + 1'b1);
    row_d    = !i_enable ? V_LAST : (col_q == H_LAST ? next_row : row_q);
    hsync_d  = (col_d >= HS_START && col_d < HS_END) ? ASSERTED : !ASSERTED;
    vsync_d  = (row_d >= VS_START && row_d < VS_END) ? ASSERTED : !ASSERTED;
    active_d = col_d < H_ACT && row_d < V_ACT;
    fs_d     = col_d == '0 && row_d == '0;
  end

  // fetch scheduling: request the next line once the current line's active part ends
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    deadline = col_q == '0 && row_q == line_q;
    und_set  = state_q == REQ && i_enable && !i_fetch_ack && deadline;
    if (state_q == IDLE) begin
      if (i_enable && col_q == H_ACT && next_row < V_ACT) begin
        state_d = REQ;
        line_d  = next_row;
      end
    end else if (!i_enable || i_fetch_ack || deadline) begin
      state_d = IDLE;
    end
    und_d = und_set | (und_q & !i_underrun_clr);
  end

  // all outputs registered together so they describe the same pixel
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      col_q    <= H_LAST;
      row_q    <= V_LAST;
      hsync_q  <= !ASSERTED;
      vsync_q  <= !ASSERTED;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      state_q  <= IDLE;
      line_q   <= '0;
      und_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      fs_q     <= fs_d;
      state_q  <= state_d;
      line_q   <= line_d;
      und_q    <= und_d;
    end
  end

  assign o_col         = col_q;
  assign o_row         = row_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_active      = active_q;
  assign o_frame_start = fs_q;
  assign o_fetch_req   = state_q == REQ;
  assign o_fetch_line  = line_q;
  assign o_underrun    = und_q;
endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: reduced-raster bench comparing the DUT every cycle to a linear-pixel-index model
module tb_video_timing_ctrl;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int ACK_DLY = 5;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_fetch_ack = 1'b0;
  logic       i_underrun_clr = 1'b0;
  logic [9:0] o_col, o_row, o_fetch_line;
  logic       o_hsync, o_vsync, o_active, o_frame_start, o_fetch_req, o_underrun;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0), .COUNT_W(10)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
    .o_col(o_col), .o_row(o_row), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_active(o_active), .o_frame_start(o_frame_start),
    .o_fetch_req(o_fetch_req), .o_fetch_line(o_fetch_line),
    .i_fetch_ack(i_fetch_ack), .o_underrun(o_underrun),
    .i_underrun_clr(i_underrun_clr)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // model: p is the linear pixel index the outputs should show
  int p = FT - 1;
  bit m_req = 0, m_und = 0;
  int m_line = 0, m_age = 0;

  always @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      p = FT - 1;
      m_req = 0;
      m_und = 0;
      m_line = 0;
      m_age = 0;
    end else begin
      bit set;
      int nrow;
      set = 0;
      nrow = (p / HT + 1) % VT;
      if (m_req) begin
        m_age++;
        if (!i_enable || i_fetch_ack) m_req = 0;
        else if (p == m_line * HT) begin
          m_req = 0;
          set = 1;
        end
      end else if (i_enable && p % HT == HA && nrow < VA) begin
        m_req = 1;
        m_line = nrow;
        m_age = 0;
      end
      m_und = set || (m_und && !i_underrun_clr);
      p = i_enable ? (p + 1) % FT : FT - 1;
    end
  end

  // ack/clear stimulus derived from the model's request state
  int mode = 4, nack_line = -1;
  bit clr_pulse = 0, clr_dl = 0;

  always @(posedge clock) begin
    #1;
    if (mode == 0) i_fetch_ack = 1'b1;
    else if (mode == 1) i_fetch_ack = m_req && m_age == ACK_DLY - 1;
    else if (mode == 2) i_fetch_ack = m_req && m_line != nack_line;
    else if (mode == 3) i_fetch_ack = m_req && p == m_line * HT;
    else i_fetch_ack = 1'($urandom % 2);
    i_underrun_clr = mode == 4 ? 1'($urandom % 2) : (clr_pulse || (clr_dl && m_req && p == m_line * HT));
  end

  // per-cycle comparison against the model plus frame statistics
  bit stats_on = 0, req_prev = 0;
  int fs_cnt = 0, act_cnt = 0, hs_low = 0, vs_low = 0, req_rises = 0;
  int ec, er;

  always @(negedge clock) begin
    ec = p % HT;
    er = p / HT;
    chk("col", o_col, ec);
    chk("row", o_row, er);
    chk("hsync", o_hsync, (ec >= HA + HF && ec < HA + HF + HS) ? 0 : 1);
    chk("vsync", o_vsync, (er >= VA + VF && er < VA + VF + VS) ? 0 : 1);
    chk("active", o_active, (ec < HA && er < VA) ? 1 : 0);
    chk("frame_start", o_frame_start, p == 0 ? 1 : 0);
    chk("fetch_req", o_fetch_req, m_req);
    if (m_req) chk("fetch_line", o_fetch_line, m_line);
    chk("underrun", o_underrun, m_und);
    if (stats_on) begin
      fs_cnt += int'(o_frame_start);
      act_cnt += int'(o_active);
      hs_low += int'(!o_hsync);
      vs_low += int'(!o_vsync);
      if (o_fetch_req && !req_prev) req_rises++;
    end
    req_prev = o_fetch_req;
  end

  task automatic wait_pos(input int c, input int r);
    int n;
    n = 0;
    while (p != r * HT + c && n < 3 * FT) begin
      @(negedge clock);
      n++;
    end
    if (p != r * HT + c) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_pos: position (%0d,%0d) not reached, model at %0d", c, r, p);
    end
  endtask

  task automatic pulse_clr();
    #1 clr_pulse = 1;
    @(negedge clock);
    #1 clr_pulse = 0;
    @(negedge clock);
    chk("underrun_cleared", o_underrun, 0);
  endtask

  initial begin
    // reset with random inputs
    repeat (4) begin
      @(negedge clock);
      #1 i_enable = 1'($urandom % 2);
    end
    @(negedge clock);
    chk("rst_col", o_col, 31);
    chk("rst_row", o_row, 16);
    chk("rst_hsync", o_hsync, 1);
    chk("rst_vsync", o_vsync, 1);
    chk("rst_req", o_fetch_req, 0);
    chk("rst_und", o_underrun, 0);
    chk("rst_line", o_fetch_line, 0);
    #1 i_enable = 0;
    mode = 0;
    i_reset = 1;
    repeat (3) @(negedge clock);
    chk("hold_col", o_col, 31);
    chk("hold_fs", o_frame_start, 0);
    // free run two frames with ack tied high
    #1 i_enable = 1;
    stats_on = 1;
    @(negedge clock);
    chk("first_col", o_col, 0);
    chk("first_row", o_row, 0);
    chk("first_fs", o_frame_start, 1);
    repeat (2 * FT - 1) @(negedge clock);
    #1 stats_on = 0;
    chk("frame_starts", fs_cnt, 2);
    chk("active_pixels", act_cnt, 2 * HA * VA);
    chk("hsync_low", hs_low, 2 * HS * VT);
    chk("vsync_low", vs_low, 2 * VS * HT);
    chk("fetch_count", req_rises, 2 * VA);
    // delayed ack
    mode = 1;
    wait_pos(21, 3);
    chk("dly_req_rise", o_fetch_req, 1);
    chk("dly_line", o_fetch_line, 4);
    wait_pos(25, 3);
    chk("dly_req_hold", o_fetch_req, 1);
    wait_pos(26, 3);
    chk("dly_req_drop", o_fetch_req, 0);
    wait_pos(21, 16);
    chk("wrap_req", o_fetch_req, 1);
    chk("wrap_line", o_fetch_line, 0);
    chk("dly_und", o_underrun, 0);
    // underrun on line 5, then clear
    wait_pos(0, 0);
    #1 nack_line = 5;
    mode = 2;
    wait_pos(0, 5);
    chk("dl_req_high", o_fetch_req, 1);
    chk("dl_und_pre", o_underrun, 0);
    wait_pos(1, 5);
    chk("dl_req_drop", o_fetch_req, 0);
    chk("dl_und_set", o_underrun, 1);
    pulse_clr();
    // set and clear in the same cycle: set wins
    #1 nack_line = 7;
    clr_dl = 1;
    wait_pos(1, 7);
    chk("setclr_und", o_underrun, 1);
    #1 clr_dl = 0;
    nack_line = -1;
    pulse_clr();
    // ack exactly at the deadline
    #1 mode = 3;
    wait_pos(0, 3);
    chk("dlack_req", o_fetch_req, 1);
    wait_pos(1, 3);
    chk("dlack_drop", o_fetch_req, 0);
    chk("dlack_und", o_underrun, 0);
    // disable during a request
    #1 mode = 1;
    wait_pos(22, 4);
    #1 i_enable = 0;
    @(negedge clock);
    chk("dis_req", o_fetch_req, 0);
    chk("dis_col", o_col, 31);
    chk("dis_row", o_row, 16);
    chk("dis_und", o_underrun, 0);
    #1 i_enable = 1;
    @(negedge clock);
    chk("reen_col", o_col, 0);
    chk("reen_fs", o_frame_start, 1);
    // asynchronous reset during a request
    wait_pos(22, 6);
    chk("pre_rst_req", o_fetch_req, 1);
    #1 i_reset = 0;
    #1;
    chk("arst_req", o_fetch_req, 0);
    chk("arst_col", o_col, 31);
    chk("arst_row", o_row, 16);
    chk("arst_hsync", o_hsync, 1);
    @(negedge clock);
    #1 i_reset = 1;
    mode = 0;
    repeat (2 * HT) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule
